// File: rtl/pu_root_unit.sv
// Union-find node unit: grows links, merges its root to the neighbourhood minimum.
// Optional PU_MERGE_COUNTER_EN adds a saturating count of merge root updates.
module pu_root_unit #(
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter int unsigned NEIGHBOR_COUNT = 6,
  parameter int unsigned ADDRESS = 0,
  parameter int unsigned STAGE_WIDTH = 3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1,
  parameter logic [STAGE_WIDTH-1:0] STAGE_GROWING = 3'd2,
  parameter logic [STAGE_WIDTH-1:0] STAGE_MERGING = 3'd3
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [STAGE_WIDTH-1:0]                  global_stage,
  input  logic                                    measurement,
  input  logic                                    cluster_odd,
  input  logic [NEIGHBOR_COUNT-1:0]               neighbor_fully_grown,
  input  logic [NEIGHBOR_COUNT-1:0]               neighbor_is_boundary,
  input  logic [NEIGHBOR_COUNT*ADDRESS_WIDTH-1:0] neighbor_root_in,
  output logic [NEIGHBOR_COUNT-1:0]               neighbor_increase,
  output logic [ADDRESS_WIDTH-1:0]                root_out,
  output logic                                    measured,
  output logic                                    touching_boundary,
  output logic                                    busy
`ifdef PU_MERGE_COUNTER_EN
  ,
  output logic [15:0]                             merge_updates
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GROW_PULSE,
    S_GROW_HOLD,
    S_MERGE
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ROOT_INIT = ADDRESS[ADDRESS_WIDTH-1:0];

  state_t                      r_state;
  state_t                      w_next;
  logic [NEIGHBOR_COUNT-1:0]   r_increase;
  logic [ADDRESS_WIDTH-1:0]    r_root;
  logic                        r_measured;
  logic                        r_touching;
  logic                        r_busy;
  logic [ADDRESS_WIDTH-1:0]    w_cand;
  logic [ADDRESS_WIDTH-1:0]    w_slot_root;
  logic                        w_lower;
  logic                        w_any_boundary;
  logic [NEIGHBOR_COUNT-1:0]   w_inc_mask;
`ifdef PU_MERGE_COUNTER_EN
  logic [15:0]                 r_merge_updates;
`endif

  // Outputs act on the decoded next state, so every state's effect is visible
  // on the cycle after global_stage first selects it.
  always_comb begin
    w_next = S_IDLE;
    if (global_stage == STAGE_MEASUREMENT_LOADING) begin
      w_next = S_LOAD;
    end else if (global_stage == STAGE_GROWING) begin
      if (r_state == S_GROW_PULSE || r_state == S_GROW_HOLD) begin
        w_next = S_GROW_HOLD;
      end else begin
        w_next = S_GROW_PULSE;
      end
    end else if (global_stage == STAGE_MERGING) begin
      w_next = S_MERGE;
    end
  end

  // Only fully grown links contribute; ties keep the current root.
  always_comb begin
    w_cand      = r_root;
    w_slot_root = '0;
    for (int unsigned i = 0; i < NEIGHBOR_COUNT; i++) begin
      w_slot_root = neighbor_root_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      if (neighbor_fully_grown[i] && (w_slot_root < w_cand)) begin
        w_cand = w_slot_root;
      end
    end
  end

  assign w_lower        = (w_cand < r_root);
  assign w_any_boundary = |(neighbor_is_boundary & neighbor_fully_grown);
  assign w_inc_mask     = (cluster_odd && !r_touching) ? ~neighbor_fully_grown : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_increase <= '0;
      r_root     <= ROOT_INIT;
      r_measured <= 1'b0;
      r_touching <= 1'b0;
      r_busy     <= 1'b0;
`ifdef PU_MERGE_COUNTER_EN
      r_merge_updates <= '0;
`endif
    end else begin
      r_state    <= w_next;
      r_increase <= '0;
      r_busy     <= 1'b0;
      case (w_next)
        S_LOAD: begin
          r_root     <= ROOT_INIT;
          r_measured <= measurement;
          r_touching <= 1'b0;
`ifdef PU_MERGE_COUNTER_EN
          r_merge_updates <= '0;
`endif
        end
        S_GROW_PULSE: begin
          r_increase <= w_inc_mask;
        end
        S_MERGE: begin
          if (w_lower) begin
            r_root <= w_cand;
            r_busy <= 1'b1;
`ifdef PU_MERGE_COUNTER_EN
            if (r_merge_updates != '1) begin
              r_merge_updates <= r_merge_updates + 16'd1;
            end
`endif
          end
          if (w_any_boundary) begin
            r_touching <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign neighbor_increase = r_increase;
  assign root_out          = r_root;
  assign measured          = r_measured;
  assign touching_boundary = r_touching;
  assign busy              = r_busy;
`ifdef PU_MERGE_COUNTER_EN
  assign merge_updates     = r_merge_updates;
`endif

endmodule

// File: tb/tb_pu_root_unit.sv
// Directed bench for pu_root_unit: three nodes (ADDRESS 5, 7, 20) share one stimulus stream.
module tb_pu_root_unit;

  localparam int unsigned AW = 9;
  localparam int unsigned NC = 6;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_GROW  = 3'd2;
  localparam logic [2:0] ST_MERGE = 3'd3;

  logic           clk;
  logic           rst;
  logic [2:0]     stage;
  logic           meas;
  logic           odd;
  logic [NC-1:0]  fg;
  logic [NC-1:0]  bnd;
  logic [NC*AW-1:0] roots;

  logic [NC-1:0] inc5, inc7, inc20;
  logic [AW-1:0] root5, root7, root20;
  logic          meas5, meas7, meas20;
  logic          tb5, tb7, tb20;
  logic          busy5, busy7, busy20;
`ifdef PU_MERGE_COUNTER_EN
  logic [15:0]   mu5, mu7, mu20;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pu_root_unit #(.ADDRESS_WIDTH(AW), .NEIGHBOR_COUNT(NC), .ADDRESS(5), .STAGE_WIDTH(3),
    .STAGE_MEASUREMENT_LOADING(ST_LOAD), .STAGE_GROWING(ST_GROW), .STAGE_MERGING(ST_MERGE)) u5 (
    .clk(clk), .reset(rst), .global_stage(stage), .measurement(meas), .cluster_odd(odd),
    .neighbor_fully_grown(fg), .neighbor_is_boundary(bnd), .neighbor_root_in(roots),
    .neighbor_increase(inc5), .root_out(root5), .measured(meas5),
    .touching_boundary(tb5), .busy(busy5)
`ifdef PU_MERGE_COUNTER_EN
    , .merge_updates(mu5)
`endif
  );

  pu_root_unit #(.ADDRESS_WIDTH(AW), .NEIGHBOR_COUNT(NC), .ADDRESS(7), .STAGE_WIDTH(3),
    .STAGE_MEASUREMENT_LOADING(ST_LOAD), .STAGE_GROWING(ST_GROW), .STAGE_MERGING(ST_MERGE)) u7 (
    .clk(clk), .reset(rst), .global_stage(stage), .measurement(meas), .cluster_odd(odd),
    .neighbor_fully_grown(fg), .neighbor_is_boundary(bnd), .neighbor_root_in(roots),
    .neighbor_increase(inc7), .root_out(root7), .measured(meas7),
    .touching_boundary(tb7), .busy(busy7)
`ifdef PU_MERGE_COUNTER_EN
    , .merge_updates(mu7)
`endif
  );

  pu_root_unit #(.ADDRESS_WIDTH(AW), .NEIGHBOR_COUNT(NC), .ADDRESS(20), .STAGE_WIDTH(3),
    .STAGE_MEASUREMENT_LOADING(ST_LOAD), .STAGE_GROWING(ST_GROW), .STAGE_MERGING(ST_MERGE)) u20 (
    .clk(clk), .reset(rst), .global_stage(stage), .measurement(meas), .cluster_odd(odd),
    .neighbor_fully_grown(fg), .neighbor_is_boundary(bnd), .neighbor_root_in(roots),
    .neighbor_increase(inc20), .root_out(root20), .measured(meas20),
    .touching_boundary(tb20), .busy(busy20)
`ifdef PU_MERGE_COUNTER_EN
    , .merge_updates(mu20)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_root(input int slot, input int val);
    roots[slot*AW +: AW] = val[AW-1:0];
  endtask

  initial begin
    rst = 1'b1; stage = ST_IDLE; meas = 1'b0; odd = 1'b0;
    fg = '0; bnd = '0; roots = '0;
    #2;
    check("rst_root5", 32'(root5), 5);
    check("rst_root20", 32'(root20), 20);
    check("rst_busy5", 32'(busy5), 0);
    check("rst_inc5", 32'(inc5), 0);
    check("rst_meas5", 32'(meas5), 0);
    check("rst_tb5", 32'(tb5), 0);
    @(negedge clk); rst = 1'b0;
    step();

    // Load then grow, odd cluster
    stage = ST_LOAD; meas = 1'b1; step();
    check("load_meas7", 32'(meas7), 1);
    check("load_root7", 32'(root7), 7);
    stage = ST_GROW; odd = 1'b1; fg = 6'b000100; step();
    check("grow_pulse_inc7", 32'(inc7), 32'b111011);
    check("grow_pulse_inc20", 32'(inc20), 32'b111011);
    step();
    check("grow_hold1_inc7", 32'(inc7), 0);
    step();
    check("grow_hold2_inc7", 32'(inc7), 0);
    stage = ST_IDLE; step();

    // Even cluster: no pulse
    stage = ST_LOAD; step();
    stage = ST_GROW; odd = 1'b0; step();
    check("even_c1_inc7", 32'(inc7), 0);
    step();
    check("even_c2_inc7", 32'(inc7), 0);
    step();
    check("even_c3_inc7", 32'(inc7), 0);

    // Merge
    stage = ST_LOAD; step();
    check("load_root20", 32'(root20), 20);
    set_root(0, 30); set_root(1, 12); set_root(2, 4);
    set_root(3, 9);  set_root(4, 25); set_root(5, 40);
    fg = 6'b001010; stage = ST_MERGE; step();
    check("merge1_root20", 32'(root20), 9);
    check("merge1_busy20", 32'(busy20), 1);
    check("merge1_root5", 32'(root5), 5);
    check("merge1_busy5", 32'(busy5), 0);
    check("merge1_root7", 32'(root7), 7);
    check("merge1_busy7", 32'(busy7), 1'b0);
    step();
    check("merge2_root20", 32'(root20), 9);
    check("merge2_busy20", 32'(busy20), 0);

    // Late-arriving lower root
    set_root(1, 3); step();
    check("late_root20", 32'(root20), 3);
    check("late_busy20", 32'(busy20), 1);
    check("late_root5", 32'(root5), 3);
    check("late_busy5", 32'(busy5), 1);
    step();
    check("late2_busy20", 32'(busy20), 0);
    check("late2_root20", 32'(root20), 3);

    // Boundary on a non-grown link is ignored
    bnd = 6'b000001; step();
    check("bnd_ungrown_tb20", 32'(tb20), 0);
    check("tie_busy20", 32'(busy20), 0);
    fg = 6'b000100; bnd = 6'b000100; step();
    check("bnd_tb20", 32'(tb20), 1);
    check("bnd_tb7", 32'(tb7), 1);
    check("bnd_root20", 32'(root20), 3);
`ifdef PU_MERGE_COUNTER_EN
    check("cnt_mu20", 32'(mu20), 2);
    check("cnt_mu5", 32'(mu5), 1);
    check("cnt_mu7", 32'(mu7), 1);
`endif

    // Grow after touching the boundary: no pulse, root retained
    stage = ST_GROW; odd = 1'b1; fg = '0; bnd = '0; step();
    check("tbgrow_inc7", 32'(inc7), 0);
    check("tbgrow_inc20", 32'(inc20), 0);
    check("tbgrow_root20", 32'(root20), 3);
    check("tbgrow_busy20", 32'(busy20), 0);
    check("tbgrow_tb5", 32'(tb5), 1);
    meas = 1'b0; stage = ST_LOAD; step();
    check("reload_tb20", 32'(tb20), 0);
    check("reload_root20", 32'(root20), 20);
    check("reload_meas20", 32'(meas20), 0);
`ifdef PU_MERGE_COUNTER_EN
    check("reload_mu20", 32'(mu20), 0);
`endif

    // Asynchronous reset during a grow pulse
    stage = ST_GROW; odd = 1'b1; fg = 6'b000100; step();
    check("pulse_inc5", 32'(inc5), 32'b111011);
    rst = 1'b1; #1;
    check("rstpulse_inc5", 32'(inc5), 0);
    stage = ST_IDLE;
    @(negedge clk); rst = 1'b0;
    step();

    // Asynchronous reset mid-merge
    stage = ST_LOAD; step();
    fg = 6'b000010; stage = ST_MERGE; step();
    check("pre_rst_root5", 32'(root5), 3);
    check("pre_rst_busy5", 32'(busy5), 1);
    rst = 1'b1; #1;
    check("midmerge_rst_root5", 32'(root5), 5);
    check("midmerge_rst_busy5", 32'(busy5), 0);
    check("midmerge_rst_inc5", 32'(inc5), 0);
    stage = ST_IDLE;
    @(negedge clk); rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
